// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole generator.
package wam_pkg;

  localparam int unsigned LfsrW = 8;
  // Feedback mask applied when the MSB shifts out (bits 0, 4, 5, 6).
  localparam logic [LfsrW-1:0] LfsrPoly = 8'h71;

  function automatic int unsigned hole_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// 8-bit Galois LFSR spawn source; advances only when adv is high.
module wam_lfsr
  import wam_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             adv,
  input  logic [LfsrW-1:0] seed,
  output logic [LfsrW-1:0] num
);

  logic [LfsrW-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = {state_q[LfsrW-2:0], 1'b0} ^ (state_q[LfsrW-1] ? LfsrPoly : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      // All-zero is a lock-up state, so a zero seed is replaced by 1.
      state_q <= (seed == '0) ? LfsrW'(1) : seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign num = state_q;

endmodule

// File: rtl/wam_gen_n.sv
// Mole lifecycle controller: tick prescaler, per-hole life counters, spawn cap and
// saturating hit/miss/escape scoring.
module wam_gen_n
  import wam_pkg::*;
#(
  parameter int unsigned N_HOLES  = 8,
  parameter int unsigned LIFE_W   = 4,
  parameter int unsigned TICK_DIV = 8,
  parameter int unsigned MAX_LIVE = 8,
  parameter int unsigned SCORE_W  = 10
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               run,
  input  logic [7:0]         seed,
  input  logic [N_HOLES-1:0] hit,
  input  logic [LIFE_W-1:0]  age,
  input  logic [7:0]         rto,
  output logic [N_HOLES-1:0] holes,
  output logic               hit_pls,
  output logic               miss_pls,
  output logic               esc_pls,
  output logic [SCORE_W-1:0] n_hit,
  output logic [SCORE_W-1:0] n_miss,
  output logic [SCORE_W-1:0] n_esc
);

  localparam int unsigned IdxW = hole_idx_w(N_HOLES);
  localparam int unsigned CntW = hole_idx_w(TICK_DIV);
  localparam logic [31:0] ScoreMax = 32'((64'd1 << SCORE_W) - 64'd1);

  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [IdxW-1:0]                ptr_q, ptr_d;
  logic [N_HOLES-1:0]             holes_q, holes_d;
  logic [N_HOLES-1:0][LIFE_W-1:0] life_q, life_d;
  logic                           hit_pls_q, hit_pls_d;
  logic                           miss_pls_q, miss_pls_d;
  logic                           esc_pls_q, esc_pls_d;
  logic [SCORE_W-1:0]             n_hit_q, n_hit_d;
  logic [SCORE_W-1:0]             n_miss_q, n_miss_d;
  logic [SCORE_W-1:0]             n_esc_q, n_esc_d;

  logic                           tick;
  logic                           spawn_ok;
  logic [5:0]                     live;
  logic [LfsrW-1:0]               rnum;
  logic [N_HOLES-1:0]             hit_ev, miss_ev, esc_ev;

  assign tick     = run && (cnt_q == CntW'(TICK_DIV - 1));
  assign live     = popcnt32(32'(holes_q));
  assign spawn_ok = tick && (rnum < rto) && (32'(live) < MAX_LIVE);

  wam_lfsr u_lfsr (
    .clk   (clk),
    .clr_n (clr_n),
    .adv   (tick),
    .seed  (seed),
    .num   (rnum)
  );

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (run) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
    if (tick) begin
      ptr_d = (ptr_q == IdxW'(N_HOLES - 1)) ? '0 : ptr_q + IdxW'(1);
    end
  end

  // Every decision below reads only pre-update state; the spawn pointer can match one hole only.
  always_comb begin
    holes_d = holes_q;
    life_d  = life_q;
    hit_ev  = '0;
    miss_ev = '0;
    esc_ev  = '0;
    if (run) begin
      for (int unsigned i = 0; i < N_HOLES; i++) begin
        if (hit[i] && holes_q[i]) begin
          holes_d[i] = 1'b0;
          life_d[i]  = '0;
          hit_ev[i]  = 1'b1;
        end else if (hit[i]) begin
          miss_ev[i] = 1'b1;
        end else if (tick && holes_q[i]) begin
          if (life_q[i] >= age) begin
            holes_d[i] = 1'b0;
            life_d[i]  = '0;
            esc_ev[i]  = 1'b1;
          end else begin
            life_d[i] = life_q[i] + LIFE_W'(1);
          end
        end else if (spawn_ok && (ptr_q == IdxW'(i))) begin
          holes_d[i] = 1'b1;
          life_d[i]  = LIFE_W'(1);
        end
      end
    end
  end

  always_comb begin
    hit_pls_d  = |hit_ev;
    miss_pls_d = |miss_ev;
    esc_pls_d  = |esc_ev;
    n_hit_d    = SCORE_W'(sat_add(32'(n_hit_q), 32'(popcnt32(32'(hit_ev))), ScoreMax));
    n_miss_d   = SCORE_W'(sat_add(32'(n_miss_q), 32'(popcnt32(32'(miss_ev))), ScoreMax));
    n_esc_d    = SCORE_W'(sat_add(32'(n_esc_q), 32'(popcnt32(32'(esc_ev))), ScoreMax));
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      holes_q    <= '0;
      life_q     <= '0;
      hit_pls_q  <= 1'b0;
      miss_pls_q <= 1'b0;
      esc_pls_q  <= 1'b0;
      n_hit_q    <= '0;
      n_miss_q   <= '0;
      n_esc_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      holes_q    <= holes_d;
      life_q     <= life_d;
      hit_pls_q  <= hit_pls_d;
      miss_pls_q <= miss_pls_d;
      esc_pls_q  <= esc_pls_d;
      n_hit_q    <= n_hit_d;
      n_miss_q   <= n_miss_d;
      n_esc_q    <= n_esc_d;
    end
  end

  assign holes    = holes_q;
  assign hit_pls  = hit_pls_q;
  assign miss_pls = miss_pls_q;
  assign esc_pls  = esc_pls_q;
  assign n_hit    = n_hit_q;
  assign n_miss   = n_miss_q;
  assign n_esc    = n_esc_q;

endmodule

// File: tb/tb_wam_gen_n.sv
// Directed bench for wam_gen_n with N_HOLES=8, TICK_DIV=4, MAX_LIVE=2, SCORE_W=4.
module tb_wam_gen_n;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       run;
  logic [7:0] seed;
  logic [7:0] hit;
  logic [3:0] age;
  logic [7:0] rto;
  logic [7:0] holes;
  logic       hit_pls, miss_pls, esc_pls;
  logic [3:0] n_hit, n_miss, n_esc;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  wam_gen_n #(
    .N_HOLES  (8),
    .LIFE_W   (4),
    .TICK_DIV (4),
    .MAX_LIVE (2),
    .SCORE_W  (4)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .run      (run),
    .seed     (seed),
    .hit      (hit),
    .age      (age),
    .rto      (rto),
    .holes    (holes),
    .hit_pls  (hit_pls),
    .miss_pls (miss_pls),
    .esc_pls  (esc_pls),
    .n_hit    (n_hit),
    .n_miss   (n_miss),
    .n_esc    (n_esc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] s);
    clr_n = 1'b0;
    seed  = s;
    hit   = '0;
    step(2);
    clr_n = 1'b1;
  endtask

  function automatic int popcnt8(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  initial begin
    clr_n = 1'b0;
    run   = 1'b1;
    seed  = 8'h00;
    hit   = '0;
    age   = 4'd2;
    rto   = 8'd255;

    // Reset with zero seed, then hold reset while hits toggle.
    step(2);
    check_eq("rst_holes", 32'(holes), 32'h00);
    check_eq("rst_n_hit", 32'(n_hit), 32'h0);
    check_eq("rst_n_miss", 32'(n_miss), 32'h0);
    check_eq("rst_n_esc", 32'(n_esc), 32'h0);
    check_eq("rst_pulses", {29'd0, hit_pls, miss_pls, esc_pls}, 32'h0);
    check_eq("rst_lfsr_zero_seed", 32'(dut.u_lfsr.num), 32'h01);
    for (int i = 0; i < 20; i++) begin
      hit = (i % 2 == 0) ? 8'hFF : 8'h00;
      step(1);
      check_eq("rsthold_holes", 32'(holes), 32'h00);
      check_eq("rsthold_n_miss", 32'(n_miss), 32'h0);
      check_eq("rsthold_miss_pls", 32'(miss_pls), 32'h0);
    end

    // Lifecycle: ticks land on edges 4, 8, 12, ... after release; rnum 01,02,04,...
    age = 4'd2;
    rto = 8'd255;
    do_reset(8'h01);
    step(3);
    check_eq("life_pre_tick", 32'(holes), 32'h00);
    step(1);
    check_eq("life_spawn0", 32'(holes), 32'h01);
    check_eq("life_ptr1", 32'(dut.ptr_q), 32'h1);
    step(4);
    check_eq("life_e8", 32'(holes), 32'h03);
    step(4);
    check_eq("life_e12_holes", 32'(holes), 32'h02);
    check_eq("life_e12_esc_pls", 32'(esc_pls), 32'h1);
    check_eq("life_e12_n_esc", 32'(n_esc), 32'h1);
    step(1);
    check_eq("life_e13_esc_pls", 32'(esc_pls), 32'h0);
    step(3);
    check_eq("life_e16_holes", 32'(holes), 32'h08);
    check_eq("life_e16_n_esc", 32'(n_esc), 32'h2);
    step(4);
    check_eq("life_e20", 32'(holes), 32'h18);

    // Hit on hole 3 in the cycle it would expire.
    step(3);
    hit = 8'h08;
    step(1);
    hit = 8'h00;
    check_eq("hve_holes", 32'(holes), 32'h10);
    check_eq("hve_hit_pls", 32'(hit_pls), 32'h1);
    check_eq("hve_esc_pls", 32'(esc_pls), 32'h0);
    check_eq("hve_n_hit", 32'(n_hit), 32'h1);
    check_eq("hve_n_esc", 32'(n_esc), 32'h2);

    // Miss on empty hole 6 == ptr at a tick; spawn there is suppressed.
    step(3);
    hit = 8'h40;
    step(1);
    hit = 8'h00;
    check_eq("miss_holes", 32'(holes), 32'h00);
    check_eq("miss_miss_pls", 32'(miss_pls), 32'h1);
    check_eq("miss_n_miss", 32'(n_miss), 32'h1);
    check_eq("miss_esc_pls", 32'(esc_pls), 32'h1);
    check_eq("miss_n_esc", 32'(n_esc), 32'h3);
    check_eq("miss_hit_pls", 32'(hit_pls), 32'h0);
    step(4);
    check_eq("life_e32", 32'(holes), 32'h80);
    step(4);
    check_eq("life_e36", 32'(holes), 32'h81);
    step(4);
    check_eq("life_e40", 32'(holes), 32'h01);
    check_eq("life_e40_n_esc", 32'(n_esc), 32'h4);

    // Cap of 2 live moles, then a hit frees a slot and spawning resumes.
    age = 4'd15;
    step(4);
    check_eq("cap_e44", 32'(holes), 32'h05);
    step(4);
    check_eq("cap_e48_full", 32'(holes), 32'h05);
    hit = 8'h01;
    step(1);
    hit = 8'h00;
    check_eq("cap_hit_holes", 32'(holes), 32'h04);
    check_eq("cap_hit_n_hit", 32'(n_hit), 32'h2);
    check_eq("cap_hit_pls", 32'(hit_pls), 32'h1);
    step(3);
    check_eq("cap_resume", 32'(holes), 32'h14);
    for (int c = 0; c < 800; c++) begin
      step(1);
      check_eq("cap_live_le2", 32'(popcnt8(holes) <= 2), 32'h1);
    end

    // Saturation: 20 single-hole misses with spawning disabled.
    rto = 8'd0;
    do_reset(8'h01);
    for (int k = 1; k <= 20; k++) begin
      hit = 8'h20;
      step(1);
      hit = 8'h00;
      check_eq("sat_miss_pls", 32'(miss_pls), 32'h1);
      check_eq("sat_n_miss", 32'(n_miss), (k > 15) ? 32'd15 : 32'(k));
      step(1);
    end

    // run=0 freezes state and ignores hits.
    rto = 8'd255;
    age = 4'd15;
    do_reset(8'h01);
    step(4);
    check_eq("frz_spawn", 32'(holes), 32'h01);
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hit = (i % 2 == 0) ? 8'hFF : 8'h00;
      step(1);
      check_eq("frz_holes", 32'(holes), 32'h01);
      check_eq("frz_counts", {24'd0, n_hit, n_miss}, 32'h0);
      check_eq("frz_pulses", {30'd0, hit_pls, miss_pls}, 32'h0);
    end
    hit = 8'h00;
    run = 1'b1;

    // rto=0: no spawns over 1000 ticks while the pointer keeps wrapping.
    rto = 8'd0;
    do_reset(8'h5A);
    for (int k = 1; k <= 1000; k++) begin
      step(4);
      check_eq("zero_holes", 32'(holes), 32'h00);
      check_eq("zero_ptr", 32'(dut.ptr_q), 32'(k % 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
